store_axi_writer: RTL
=====================

Name: store_axi_writer

Overview:
Store-side counterpart of the load data path. Accepts one store request (address, register data, funct3) from the LSU and aligns the data into a 32-bit word lane with byte strobes. Issues the write as a single AXI4-Lite AW/W/B transaction and returns a completion with an error flag. It sits between the LSU and the data-memory/crossbar write port.

Parameters:
ADDR_W, 32, request/bus address width
DATA_W, 32, bus data width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  store request valid
req_ready  out  1  request accepted when valid&ready
req_addr  in  ADDR_W  byte address
req_data  in  32  rs2 value, unaligned (LSB-justified)
req_funct3  in  3  FUNCT3_SB=000, FUNCT3_SH=001, FUNCT3_SW=010
resp_valid  out  1  completion valid
resp_ready  in  1  completion consumed when valid&ready
resp_err  out  1  1 = bus error or illegal request
awvalid  out  1  AXI write address valid
awready  in  1
awaddr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
wvalid  out  1
wready  in  1
wdata  out  32  lane-aligned data
wstrb  out  4  byte strobes
bvalid  in  1
bready  out  1
bresp  in  2  00 = OKAY; any other value = error

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1; resp_valid=0; resp_err=0; awvalid=0; wvalid=0; bready=0; awaddr, wdata, wstrb=0.
- States: IDLE, SEND, WAIT_B, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and compute alignment. Legal request -> SEND. Illegal request -> RESP with err=1, no bus activity.
- Alignment (off=req_addr[1:0]):
  - SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001<<off.
  - SH: wdata = {2{data[15:0]}}, wstrb = 4'b0011<<off.
  - SW: wdata = data, wstrb = 4'b1111.
- Illegal: funct3 not in {000,001,010}.
- SEND (entered the cycle after acceptance): awvalid=1 and wvalid=1 together.
  - Each channel drops its valid the cycle after its own handshake. Tracked by per-channel done flags.
  - AW and W may complete in the same cycle or in either order.
  - awaddr, wdata, wstrb stay stable while the corresponding valid is high.
  - Both done -> WAIT_B.
- WAIT_B: bready=1. On bvalid, capture err=(bresp!=2'b00) -> RESP.
- RESP: resp_valid=1, resp_err held stable, req_ready=0. On resp_ready -> IDLE. A new request can be accepted the cycle after.
- Minimum latency (all readies high, bvalid the cycle after AW/W): accept at cycle N, AW/W handshake at N+1, B at N+2, resp_valid at N+3.
- Only one outstanding transaction; req_ready=0 in every state except IDLE.
- bvalid outside WAIT_B is ignored; bready is never high outside WAIT_B.
- rst_n asserted mid-transaction: all valids drop immediately and the in-flight transaction is abandoned. No resp is produced.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: SH with req_addr[0]=1, or SW with req_addr[1:0]!=0, is treated as illegal. Goes IDLE->RESP with resp_err=1 and no AW/W issued.
- Not defined: misaligned halfword/word low address bits are ignored for lane selection.
  - SH uses off&2'b10.
  - SW always uses strobe 4'b1111.
  - The transaction is issued normally.

Test Plan:
- SB addr=0x8000_0003 data=0x1234_56AB, all readies 1 -> awaddr=0x8000_0000, wdata=0xABABABAB, wstrb=4'b1000. resp_valid at accept+3 with resp_err=0.
- SH addr=0x8000_0002 data=0xFFFF_BEEF -> wdata=0xBEEFBEEF, wstrb=4'b1100. SW addr=0x10 data=0xDEADBEEF -> wstrb=4'b1111.
- awready held 0 for 3 cycles while wready=1 -> W handshakes first, then wvalid=0. awvalid/awaddr stay stable until awready. bready rises only after both handshakes.
- bresp=2'b10 -> resp_err=1. Hold resp_ready=0 for 4 cycles -> resp_valid/resp_err stable and req_ready=0 throughout.
- funct3=3'b011 -> no awvalid/wvalid, resp_valid=1 with resp_err=1. With MISALIGN_TRAP_EN, SW addr=0x...1 -> same result. Without it -> normal write, wstrb=4'b1111.
- rst_n pulsed low during WAIT_B -> bready, awvalid, wvalid drop asynchronously. After release, req_ready=1 and resp_valid=0.

Source files
------------

// File: rtl/store_axi_writer.sv
// Store writer: aligns an LSU store into a 32-bit lane with strobes and issues it as one AXI4-Lite AW/W/B write.
// Latency: accept at cycle N, AW/W at N+1, B at N+2 (earliest), completion visible at N+3.
// Backpressure: one transaction in flight; req_ready only in IDLE; completion held until resp_ready.
// Optional: `define MISALIGN_TRAP_EN to reject misaligned SH/SW as illegal instead of issuing them.
module store_axi_writer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_funct3,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] WAIT_B = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]        state;
  logic              aw_done;
  logic              w_done;
  logic [1:0]        off;
  logic [DATA_W-1:0] lane_data;
  logic [3:0]        lane_strb;
  logic              legal;
  logic              aw_hs;
  logic              w_hs;

  // Valids are pure functions of state so a reset drops them immediately.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign bready     = (state == WAIT_B);
  assign awvalid    = (state == SEND) && !aw_done;
  assign wvalid     = (state == SEND) && !w_done;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;

  // Replicate the store data across the word and pick byte strobes from the low address bits.
  always_comb begin
    off       = req_addr[1:0];
    lane_data = req_data;
    lane_strb = 4'b1111;
    legal     = 1'b1;
    case (req_funct3)
      3'b000: begin
        lane_data = {4{req_data[7:0]}};
        lane_strb = 4'b0001 << off;
      end
      3'b001: begin
        lane_data = {2{req_data[15:0]}};
        lane_strb = 4'b0011 << (off & 2'b10);
`ifdef MISALIGN_TRAP_EN
        if (off[0]) legal = 1'b0;
`endif
      end
      3'b010: begin
        lane_data = req_data;
        lane_strb = 4'b1111;
`ifdef MISALIGN_TRAP_EN
        if (off != 2'b00) legal = 1'b0;
`endif
      end
      default: legal = 1'b0;
    endcase
  end

  // Transaction sequencer: accept, drive AW/W until each handshakes, wait for B, hold completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      resp_err <= 1'b0;
      awaddr   <= '0;
      wdata    <= '0;
      wstrb    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              wdata   <= lane_data;
              wstrb   <= lane_strb;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= SEND;
            end else begin
              resp_err <= 1'b1;
              state    <= RESP;
            end
          end
        end
        SEND: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WAIT_B;
        end
        WAIT_B: begin
          if (bvalid) begin
            resp_err <= (bresp != 2'b00);
            state    <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
